// File: rtl/cfg_frame_rx.sv
// cfg_frame_rx - upstream stage of the configuration-info parser.
//
// Captures one configuration frame from the serial-link byte stream into a
// local buffer and checks its length (and its CRC when CFG_CRC_CHK_EN is
// defined). An accepted payload is then replayed to the parser as a
// slink_cfg_dval/slink_cfg_data word stream that ends with a marker word.
// Until the first good frame has been replayed, cfg_req pulses every
// REQ_PERIOD idle cycles to ask the far end for configuration.
//
// Build option:
//   CFG_CRC_CHK_EN - frame carries 2 trailing CRC-16/CCITT bytes (high byte
//                    first) over the payload; a mismatch rejects the frame.
//
// Ports:
//   clk_sys, rst_sys_n          clock, async active-low reset
//   rx_dval/rx_sof/rx_eof       link byte qualifiers (sof/eof gated by dval)
//   rx_data[7:0]                link byte
//   slink_cfg_dval              replay word valid
//   slink_cfg_data[9:0]         [7:0] payload byte, [8] end marker, [9] 0
//   cfg_req                     one-cycle configuration request
//   cfg_got                     sticky, a good frame has been replayed
//   busy                        FSM not idle
//   frm_ok_cnt, frm_err_cnt     saturating accepted / rejected frame counts
module cfg_frame_rx #(
  parameter int PAYLOAD_LEN = 16,
  parameter int REQ_PERIOD  = 50000,
  parameter int PLAY_GAP    = 1
) (
  input  logic       clk_sys,
  input  logic       rst_sys_n,
  input  logic       rx_dval,
  input  logic       rx_sof,
  input  logic       rx_eof,
  input  logic [7:0] rx_data,
  output logic       slink_cfg_dval,
  output logic [9:0] slink_cfg_data,
  output logic       cfg_req,
  output logic       cfg_got,
  output logic       busy,
  output logic [7:0] frm_ok_cnt,
  output logic [7:0] frm_err_cnt
);

`ifdef CFG_CRC_CHK_EN
  localparam int FRAME_LEN = PAYLOAD_LEN + 2;
`else
  localparam int FRAME_LEN = PAYLOAD_LEN;
`endif
  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TW = $clog2(REQ_PERIOD);
  localparam int GW = (PLAY_GAP > 0) ? $clog2(PLAY_GAP + 1) : 1;

  localparam logic [5:0]    FL    = 6'(FRAME_LEN);
  localparam logic [AW-1:0] RLAST = AW'(PAYLOAD_LEN - 1);
  localparam logic [TW-1:0] TTERM = TW'(REQ_PERIOD - 1);
  localparam logic [GW-1:0] GAP   = GW'(PLAY_GAP);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] MARK  = 3'd4;

  logic [2:0]    state;
  logic [5:0]    wptr;
  logic [AW-1:0] rptr;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] req_tmr;
  logic [7:0]    frame_buf [FRAME_LEN];

  logic          sof_in, buf_we, crc_ok, good, ok_evt, err_evt, step_done;
  logic [AW-1:0] buf_wa;

  assign sof_in = rx_dval & rx_sof;
  assign busy   = (state != IDLE);

  // A sof always lands in slot 0; other bytes only while room remains, so
  // an over-long frame can never spill into the replayed region.
  assign buf_we = ((state == IDLE) && sof_in) ||
                  ((state == RECV) && rx_dval && (rx_sof || (wptr < FL)));
  assign buf_wa = rx_sof ? '0 : wptr[AW-1:0];

  always_ff @(posedge clk_sys) begin
    if (buf_we) frame_buf[buf_wa] <= rx_data;
  end

`ifdef CFG_CRC_CHK_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Running CRC over payload bytes only; the trailing CRC bytes are just
  // stored and compared in CHECK.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) crc_q <= 16'hFFFF;
    else if (sof_in && (state == IDLE || state == RECV)) crc_q <= crc_upd(16'hFFFF, rx_data);
    else if (state == RECV && rx_dval && wptr < 6'(PAYLOAD_LEN)) crc_q <= crc_upd(crc_q, rx_data);
  end

  assign crc_ok = (crc_q == {frame_buf[AW'(PAYLOAD_LEN)], frame_buf[AW'(PAYLOAD_LEN + 1)]});
`else
  assign crc_ok = 1'b1;
`endif

  assign good    = (wptr == FL) && crc_ok;
  assign ok_evt  = (state == CHECK) && good;
  // Abort, stray sof and bad frame are OR-ed so coincident errors count once.
  assign err_evt = (sof_in && state != IDLE) || ((state == CHECK) && !good);

  // Replay pacing: one emit cycle (gap_cnt == 0) followed by PLAY_GAP idle cycles.
  assign step_done = (gap_cnt == GAP);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      gap_cnt     <= '0;
      cfg_got     <= 1'b0;
      frm_ok_cnt  <= '0;
      frm_err_cnt <= '0;
    end else begin
      if (ok_evt && frm_ok_cnt != 8'hFF)   frm_ok_cnt  <= frm_ok_cnt + 8'd1;
      if (err_evt && frm_err_cnt != 8'hFF) frm_err_cnt <= frm_err_cnt + 8'd1;
      case (state)
        IDLE: if (sof_in) begin
          wptr  <= 6'd1;
          state <= rx_eof ? CHECK : RECV;
        end
        RECV: if (rx_dval) begin
          if (rx_sof)              wptr <= 6'd1;
          else if (wptr != 6'd63)  wptr <= wptr + 6'd1;
          if (rx_eof)              state <= CHECK;
        end
        CHECK: begin
          rptr    <= '0;
          gap_cnt <= '0;
          state   <= good ? PLAY : IDLE;
        end
        PLAY: if (step_done) begin
          gap_cnt <= '0;
          if (rptr == RLAST) state <= MARK;
          else               rptr  <= rptr + 1'b1;
        end else gap_cnt <= gap_cnt + 1'b1;
        MARK: if (step_done) begin
          gap_cnt <= '0;
          cfg_got <= 1'b1;
          state   <= IDLE;
        end else gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // Request timer: frozen at 0 while a frame is in flight, stopped for good
  // once configured.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      req_tmr <= '0;
      cfg_req <= 1'b0;
    end else if (cfg_got || busy) begin
      req_tmr <= '0;
      cfg_req <= 1'b0;
    end else if (req_tmr == TTERM) begin
      req_tmr <= '0;
      cfg_req <= 1'b1;
    end else begin
      req_tmr <= req_tmr + 1'b1;
      cfg_req <= 1'b0;
    end
  end

  // Decoded straight from state so the stream drops with reset, not a clock later.
  assign slink_cfg_dval = ((state == PLAY) || (state == MARK)) && (gap_cnt == '0);
  assign slink_cfg_data = !slink_cfg_dval ? 10'h000 :
                          (state == MARK) ? 10'h100 : {2'b00, frame_buf[rptr]};

endmodule

// File: tb/tb_cfg_frame_rx.sv
module tb_cfg_frame_rx;
`ifdef CFG_CRC_CHK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clk_sys = 1'b0;
  logic       rst_sys_n = 1'b0;
  logic       rx_dval = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       slink_cfg_dval, cfg_req, cfg_got, busy;
  logic [9:0] slink_cfg_data;
  logic [7:0] frm_ok_cnt, frm_err_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk_sys = ~clk_sys;

  cfg_frame_rx #(.PAYLOAD_LEN(16), .REQ_PERIOD(10), .PLAY_GAP(1)) u_dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .rx_dval(rx_dval), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_data(rx_data),
    .slink_cfg_dval(slink_cfg_dval), .slink_cfg_data(slink_cfg_data),
    .cfg_req(cfg_req), .cfg_got(cfg_got), .busy(busy),
    .frm_ok_cnt(frm_ok_cnt), .frm_err_cnt(frm_err_cnt)
  );

  // Replay monitor: every valid word with the cycle it was seen in.
  logic [9:0] q_data[$];
  int         q_cyc[$];
  int         ncyc = 0;
  always @(negedge clk_sys) begin
    ncyc <= ncyc + 1;
    if (slink_cfg_dval) begin
      q_data.push_back(slink_cfg_data);
      q_cyc.push_back(ncyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] b[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[k])
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ b[k][i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction

  task automatic drive(input logic sof, input logic eof, input logic [7:0] d);
    rx_dval = 1'b1; rx_sof = sof; rx_eof = eof; rx_data = d;
    @(posedge clk_sys); #1;
    rx_dval = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
  endtask

  // Payload base, base+1, ...; CRC appended in CRC builds when the frame is closed.
  task automatic send(input logic [7:0] base, input int n, input bit eof_end, input bit bad_crc);
    logic [7:0]  b[$];
    logic [15:0] c;
    for (int i = 0; i < n; i++) b.push_back(base + 8'(i));
    if (CRC_ON && eof_end) begin
      c = crc16(b);
      b.push_back(c[15:8]);
      b.push_back(c[7:0] ^ {7'd0, bad_crc});
    end
    for (int i = 0; i < b.size(); i++) drive(i == 0, eof_end && (i == b.size() - 1), b[i]);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) begin @(posedge clk_sys); #1; end
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic expect_first(input string tag, input logic [7:0] base);
    @(negedge clk_sys); chk({tag, "_lat_check"}, 32'(slink_cfg_dval), 0);
    @(negedge clk_sys); chk({tag, "_lat_play"}, 32'(slink_cfg_dval), 1);
    chk({tag, "_first"}, 32'(slink_cfg_data), {24'd0, base});
  endtask

  task automatic check_replay(input string tag, input logic [7:0] base, input int n);
    chk({tag, "_nwords"}, q_data.size(), n + 1);
    for (int i = 0; i < n && i < q_data.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(q_data[i]), {22'd0, 2'b00, base + 8'(i)});
    if (q_data.size() == n + 1) chk({tag, "_marker"}, 32'(q_data[n]), 32'h100);
    for (int i = 0; i + 1 < q_cyc.size(); i++)
      chk($sformatf("%s_gap%0d", tag, i), q_cyc[i+1] - q_cyc[i], 2);
  endtask

  task automatic qclr();
    q_data.delete();
    q_cyc.delete();
  endtask

  initial begin
    int np;
    // Reset state
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_dval", 32'(slink_cfg_dval), 0);
    chk("rst_data", 32'(slink_cfg_data), 0);
    chk("rst_req", 32'(cfg_req), 0);
    chk("rst_got", 32'(cfg_got), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ok", 32'(frm_ok_cnt), 0);
    chk("rst_err", 32'(frm_err_cnt), 0);

    // Request pulses at cycles 10, 20, 30 after release
    @(negedge clk_sys); rst_sys_n = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(posedge clk_sys); #1;
      chk($sformatf("req_c%0d", i), 32'(cfg_req), 32'(i % 10 == 0));
    end

    // Short and long frames are rejected and never replayed
    qclr();
    send(8'h00, 15, 1'b1, 1'b0); wait_idle("short");
    chk("short_err", 32'(frm_err_cnt), 1);
    send(8'h00, 17, 1'b1, 1'b0); wait_idle("long");
    chk("long_err", 32'(frm_err_cnt), 2);
    chk("bad_nodval", q_data.size(), 0);

    // Single-byte frame goes straight to CHECK and fails length
    drive(1'b1, 1'b1, 8'hAA); wait_idle("single");
    chk("single_err", 32'(frm_err_cnt), 3);

    // Stray byte in IDLE is ignored
    drive(1'b0, 1'b0, 8'h55);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_err", 32'(frm_err_cnt), 3);

    // Aborted frame followed by a good one; only the second is replayed
    qclr();
    send(8'h80, 5, 1'b0, 1'b0);
    send(8'h00, 16, 1'b1, 1'b0);
    expect_first("f1", 8'h00);
    wait_idle("f1");
    check_replay("f1", 8'h00, 16);
    chk("f1_err", 32'(frm_err_cnt), 4);
    chk("f1_ok", 32'(frm_ok_cnt), 1);
    chk("f1_got", 32'(cfg_got), 1);

    // No requests once configured
    np = 0;
    repeat (40) begin @(posedge clk_sys); #1; if (cfg_req) np++; end
    chk("req_after_got", np, 0);

    // A sof arriving during replay is dropped and counted
    qclr();
    send(8'h20, 16, 1'b1, 1'b0);
    expect_first("f2", 8'h20);
    @(posedge clk_sys); #1;
    drive(1'b1, 1'b1, 8'hEE);
    wait_idle("f2");
    check_replay("f2", 8'h20, 16);
    chk("f2_err", 32'(frm_err_cnt), 5);
    chk("f2_ok", 32'(frm_ok_cnt), 2);

    // Reset while replaying byte 7
    qclr();
    send(8'h40, 16, 1'b1, 1'b0);
    for (int i = 0; i < 100 && q_data.size() < 7; i++) begin @(posedge clk_sys); #1; end
    chk("mid_reach", q_data.size(), 7);
    @(posedge clk_sys); #1;
    chk("mid_pre_dval", 32'(slink_cfg_dval), 1);
    chk("mid_pre_data", 32'(slink_cfg_data), 32'h047);
    rst_sys_n = 1'b0;
    #1;
    chk("mid_dval", 32'(slink_cfg_dval), 0);
    chk("mid_ok", 32'(frm_ok_cnt), 0);
    chk("mid_err", 32'(frm_err_cnt), 0);
    chk("mid_got", 32'(cfg_got), 0);
    chk("mid_busy", 32'(busy), 0);
    @(negedge clk_sys); rst_sys_n = 1'b1;
    qclr();
    send(8'h50, 16, 1'b1, 1'b0);
    expect_first("f3", 8'h50);
    wait_idle("f3");
    check_replay("f3", 8'h50, 16);
    chk("f3_ok", 32'(frm_ok_cnt), 1);
    chk("f3_err", 32'(frm_err_cnt), 0);
    chk("f3_got", 32'(cfg_got), 1);

`ifdef CFG_CRC_CHK_EN
    // Corrupted CRC low byte rejects the frame
    qclr();
    send(8'h60, 16, 1'b1, 1'b1); wait_idle("crcbad");
    chk("crcbad_err", 32'(frm_err_cnt), 1);
    chk("crcbad_ok", 32'(frm_ok_cnt), 1);
    chk("crcbad_nodval", q_data.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
